// File: rtl/enc_gen_pkg.sv
// Shared state encoding and default timing constants for the enc bounce generator.
package enc_gen_pkg;

  typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE, HOLD} enc_gen_state_t;

  // 100 ns glitches, 10 us hold at a 20 ns clock
  localparam int unsigned GLITCH_W_DEF   = 5;
  localparam int unsigned NUM_GLITCH_DEF = 7;
  localparam int unsigned HOLD_DEF       = 500;

endpackage

// File: rtl/enc_gen_cnt.sv
// Loadable down-counter shared by the glitch and hold phases; stops at zero.
module enc_gen_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] value_q;
  logic [CNT_W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (dec && (value_q != '0)) begin
      value_d = value_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign zero  = (value_q == '0);

endmodule

// File: rtl/enc_bounce_gen.sv
// Generates a burst of enc toggles followed by a held target level, with busy/done handshake.
module enc_bounce_gen
  import enc_gen_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned NUM_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             target,
  input  logic [NUM_W-1:0] num_glitch,
  input  logic [CNT_W-1:0] glitch_w,
  input  logic [CNT_W-1:0] hold_len,
  output logic             busy,
  output logic             done,
  output logic             enc
);

  enc_gen_state_t   state_q, state_d;
  logic [NUM_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] w_m1_q, w_m1_d;
  logic [CNT_W-1:0] h_m1_q, h_m1_d;
  logic             target_q, target_d;
  logic             enc_q, enc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_load_val;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_zero;

  // Phase length minus one, with a zero request treated as one cycle
  logic [CNT_W-1:0] in_w_m1;
  logic [CNT_W-1:0] in_h_m1;
  assign in_w_m1 = (glitch_w == '0) ? '0 : glitch_w - CNT_W'(1);
  assign in_h_m1 = (hold_len == '0) ? '0 : hold_len - CNT_W'(1);

  enc_gen_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_load_val),
    .value    (cnt_value),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    w_m1_d       = w_m1_q;
    h_m1_d       = h_m1_q;
    target_d     = target_q;
    enc_d        = enc_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    // Count down whenever a phase is running; a reload overrides this
    cnt_dec      = (cnt_value != '0);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          target_d     = target;
          w_m1_d       = in_w_m1;
          h_m1_d       = in_h_m1;
          rem_d        = num_glitch;
          cnt_load     = 1'b1;
          cnt_load_val = in_w_m1;
          busy_d       = 1'b1;
          state_d      = (num_glitch != '0) ? BOUNCE : SETTLE;
        end
      end
      BOUNCE: begin
        if (cnt_zero) begin
          enc_d        = ~enc_q;
          rem_d        = rem_q - NUM_W'(1);
          cnt_load     = 1'b1;
          cnt_load_val = w_m1_q;
          if (rem_q == NUM_W'(1)) begin
            state_d = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (cnt_zero) begin
          enc_d        = target_q;
          cnt_load     = 1'b1;
          cnt_load_val = h_m1_q;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (cnt_zero) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      w_m1_q   <= '0;
      h_m1_q   <= '0;
      target_q <= 1'b0;
      enc_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      w_m1_q   <= w_m1_d;
      h_m1_q   <= h_m1_d;
      target_q <= target_d;
      enc_q    <= enc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign enc  = enc_q;

endmodule

// File: tb/tb_enc_bounce_gen.sv
// Directed bench for enc_bounce_gen: burst timing, clamped zero config, ignored starts, reset abort.
module tb_enc_bounce_gen;
  import enc_gen_pkg::*;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned NUM_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             target;
  logic [NUM_W-1:0] num_glitch;
  logic [CNT_W-1:0] glitch_w;
  logic [CNT_W-1:0] hold_len;
  logic             busy;
  logic             done;
  logic             enc;

  int n_checks = 0;
  int n_errors = 0;
  logic lvl;

  always #5 clk = ~clk;

  enc_bounce_gen #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .target     (target),
    .num_glitch (num_glitch),
    .glitch_w   (glitch_w),
    .hold_len   (hold_len),
    .busy       (busy),
    .done       (done),
    .enc        (enc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic e_enc, input logic e_busy, input logic e_done);
    chk({tag, " enc"},  32'(enc),  32'(e_enc));
    chk({tag, " busy"}, 32'(busy), 32'(e_busy));
    chk({tag, " done"}, 32'(done), 32'(e_done));
  endtask

  // Idle cycles: outputs must stay put
  task automatic idle(input int n, input logic e_enc);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk_outs($sformatf("idle%0d", i), e_enc, 1'b0, 1'b0);
    end
  endtask

  // Accept a burst at edge T and check every cycle until done (c = total).
  // spur_a/spur_b: cycles whose edge sees a stray start with junk config.
  // abort_c: pulse reset mid-cycle after edge T+abort_c instead of finishing.
  task automatic run_burst(input logic tgt, input int n, input int gw, input int hl,
                           input int spur_a, input int spur_b, input int abort_c);
    int w, h, total;
    logic e_enc;
    w = (gw == 0) ? 1 : gw;
    h = (hl == 0) ? 1 : hl;
    total = (n + 1) * w + h;
    target = tgt; num_glitch = NUM_W'(n); glitch_w = CNT_W'(gw); hold_len = CNT_W'(hl);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c <= total; c++) begin
      if (c > 0) begin
        if (c == spur_a || c == spur_b) begin
          start = 1'b1; target = ~tgt; num_glitch = NUM_W'(3);
          glitch_w = CNT_W'(2); hold_len = CNT_W'(1);
        end
        @(posedge clk); #1;
        start = 1'b0;
      end
      if (c >= (n + 1) * w) e_enc = tgt;
      else                  e_enc = lvl ^ 1'((c / w) & 1);
      chk_outs($sformatf("burst c=%0d", c), e_enc, (c < total), (c == total));
      if (c == abort_c) begin
        #2 rst = 1'b1;
        #1 chk_outs("abort immediate", 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk_outs("abort held", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        lvl = 1'b0;
        return;
      end
    end
    lvl = tgt;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; target = 1'b0;
    num_glitch = '0; glitch_w = '0; hold_len = '0;
    lvl = 1'b0;
    #15 rst = 1'b0;
    #1 chk_outs("reset", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    idle(2, 1'b0);

    // target 0, 7 glitches of 5 cycles, 500 hold: enc=0 at T+40, done at T+540
    run_burst(1'b0, int'(NUM_GLITCH_DEF), int'(GLITCH_W_DEF), int'(HOLD_DEF), -1, -1, -1);
    chk("case2 level after done", 32'(enc), 32'(0));
    idle(3, 1'b0);

    // target 1, 8 glitches end at 0, then enc=1 at T+45, done at T+545
    run_burst(1'b1, 8, 5, 500, -1, -1, -1);
    idle(2, 1'b1);

    // zero config clamps to one cycle: enc=target after T+1, done after T+2
    run_burst(1'b0, 0, 0, 0, -1, -1, -1);
    idle(2, 1'b0);

    // stray starts mid-bounce (T+7) and on the done edge (T+3*4+6=18) are ignored
    run_burst(1'b1, 2, 4, 6, 7, 18, -1);
    // accepted on the very next edge, bursting from the held level 1
    run_burst(1'b0, 3, 2, 3, -1, -1, -1);
    idle(2, 1'b0);

    // reset at T+20 of a default burst aborts it, then a full burst runs normally
    run_burst(1'b1, 1, 3, 2, -1, -1, -1);
    run_burst(1'b0, 7, 5, 500, -1, -1, 20);
    idle(3, 1'b0);
    run_burst(1'b1, 7, 5, 20, -1, -1, -1);
    idle(2, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/enc_bounce_gen.md
# enc_bounce_gen

Synthesizable source for the `enc` line consumed by the encoder/debounce block. On each request it emits a programmable burst of bounce glitches, then drives a stable target level for a programmable hold time. It sits in the lab top level between the control logic (or bench sequencer) and the encoder input, and replaces hand-timed `#delay` stimulus with a cycle-exact, repeatable waveform.

## Interface
Parameters:
- `CNT_W`, default 16: width of the glitch-width and hold counters.
- `NUM_W`, default 4: width of the glitch-count field.

Ports:
- `clk` input, 1: single clock; all logic is on the rising edge.
- `rst` input, 1: asynchronous, active-high reset.
- `start` input, 1: request pulse; sampled only in IDLE.
- `target` input, 1: final stable level; latched on an accepted `start`.
- `num_glitch` input, NUM_W: number of `enc` toggles in the bounce burst; latched on an accepted `start`.
- `glitch_w` input, CNT_W: cycles per glitch phase; latched on an accepted `start`; a value of 0 is treated as 1.
- `hold_len` input, CNT_W: cycles the target level is held before `done`; latched on an accepted `start`; a value of 0 is treated as 1.
- `busy` output, 1: high from the cycle after acceptance until `done`.
- `done` output, 1: one-cycle pulse at the end of the hold time.
- `enc` output, 1: generated encoder line, registered with no glitch-prone logic on the output.

## Operation
- States (shared enum): IDLE, BOUNCE, SETTLE, HOLD.
- IDLE: `start`=1 latches all config inputs, loads `cnt` = w−1 (w = max(glitch_w,1)), `rem` = num_glitch.
  - Next state is BOUNCE if `rem`≠0, otherwise SETTLE.
- BOUNCE: `cnt` decrements each cycle. At `cnt`==0:
  - `enc` toggles, `rem` decrements, and `cnt` reloads w−1.
  - When the toggle consumes the last glitch, the next state is SETTLE.
- SETTLE: run one more w-cycle phase. At `cnt`==0:
  - `enc`<=latched target.
  - `cnt` loads h−1 (h = max(hold_len,1)).
  - Next state is HOLD.
- HOLD: `cnt` decrements. At `cnt`==0: `done`=1 for one cycle, `busy`=0, next state is IDLE.
- The latched target may equal the current `enc`. No toggle occurs in that case; the phase timing is unchanged.
- `start` while `busy`=1 is ignored. Nothing is queued and no error is raised.
- Config input changes while busy have no effect.
- `enc` keeps its last value across idle periods. The next burst starts toggling from that level.
- Arithmetic is unsigned and counters never wrap:
  - the reload value is always ≥0;
  - w−1 and h−1 are computed after clamping to ≥1.

## Timing
- Reset values, applied immediately on asynchronous assertion: `enc`=0, `busy`=0, `done`=0, state=IDLE, `cnt`=0, `rem`=0.
- Reset asserted mid-burst aborts the operation at once: `enc` goes to 0 with no `done` pulse.
- Cycle references below count from the edge T where `start` is accepted.
- `busy`=1 is visible after edge T.
- Toggle k (k = 1..N) of `enc` is visible after edge T+k·w.
- `enc`=target is visible after edge T+(N+1)·w.
- `done`=1 and `busy`=0 are visible after edge T+(N+1)·w+h.
- `start` sampled high on the same edge where `done` is driven is ignored. The earliest accept is the following edge.
- Total busy cycles = (N+1)·w + h.

## Structure
- Package `enc_gen_pkg`:
  - `typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE, HOLD} enc_gen_state_t`;
  - default constants `GLITCH_W_DEF`=5, `NUM_GLITCH_DEF`=7, `HOLD_DEF`=500 (100 ns and 10 µs at a 20 ns clock).
- One sub-module, `enc_gen_cnt`: a loadable CNT_W down-counter with `load`, `value` and `zero` outputs. It is shared by the glitch and hold phases.
- The FSM, latches and `enc` register live in the top module.

## Test plan
1. Reset with `rst`=1 for 15 ns, then release → `enc`=0, `busy`=0, `done`=0; `rst` reasserted at any later point forces the same values immediately.
2. `start` with target=0, N=7, w=5, h=500 → 7 `enc` toggles 5 cycles apart (0→1→0…→1), then `enc`=0 at T+40. `done` at T+540 and `busy` is high for exactly 540 cycles.
3. `start` with target=1, N=8, w=5, h=500 → 8 toggles end at 0, then `enc`=1 at T+45 and `done` at T+545.
4. N=0, w=0, h=0 → `enc`=target after edge T+1 and `done` after edge T+2.
5. Second `start` pulsed mid-BOUNCE and again on the `done` cycle → both are ignored. A `start` one cycle later is accepted and the burst begins from the held level.
6. `rst` pulsed at T+20 of the case-2 burst → `enc`=0 and `busy`=0 immediately, no `done` pulse. A new `start` then runs a full burst normally.
